nn_inference_seq: RTL
=====================

Name: nn_inference_seq

Overview:
- Top-level sequencer between the UART image receiver and the shared fully-connected layer engine.
- Detects each newly received 121-bit image, latches it, and runs the single layer engine once per layer in order.
- Captures the final class index and sends it back as one ASCII digit through the UART transmitter handshake.
- Flags images that arrive while an inference is in flight (overrun).

Parameters:
- NUM_LAYERS, 2, number of layers run in sequence on the shared engine (>=1)
- LAYER_W, 2, width of eng_layer; must hold NUM_LAYERS-1
- IMG_BITS, 121, image width (11x11 binary pixels)
- TIMEOUT_CYCLES, 1000000, engine watchdog limit in clk cycles (timeout feature only)
- TO_W, 20, watchdog counter width; must hold TIMEOUT_CYCLES-1

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- sw_0  input  1  run enable; low = synchronous abort to IDLE and clear flags
- input_valid  input  1  receiver image-valid; level signal, stays high once set
- network_input  input  IMG_BITS  receiver image word
- img_out  output  IMG_BITS  latched image presented to the engine
- eng_start  output  1  one-cycle start pulse to the engine
- eng_layer  output  LAYER_W  layer index for the current engine run
- eng_done  input  1  one-cycle engine completion pulse
- eng_class  input  4  class index from the engine, valid with eng_done on the last layer
- tx_data  output  8  byte to the UART transmitter
- tx_en  output  1  one-cycle transmit request
- tx_busy  input  1  transmitter busy
- result  output  4  last class index
- result_valid  output  1  result holds a completed inference
- busy  output  1  high in any state other than IDLE
- overrun  output  1  sticky: image arrived while busy
- timeout  output  1  sticky: engine watchdog expired

Behaviour:
- All registered outputs are 0 on rst; the FSM resets to IDLE.
- sw_0 low has the same effect as rst, applied synchronously, except that ivq and nq keep updating.
- Image detection:
  - ivq is input_valid and nq is network_input, each registered one cycle.
  - new_img = (input_valid & ~ivq) | (input_valid & ivq & (network_input != nq)).
  - An identical image re-sent back-to-back is not re-run (accepted limitation).
- FSM states: IDLE, START, WAIT, TX.
- IDLE:
  - On new_img: img_out <= network_input, eng_layer <= 0, result_valid <= 0, go to START.
- START:
  - eng_start = 1 for exactly this one cycle, then go to WAIT.
  - eng_done is ignored in START.
- WAIT:
  - On eng_done with eng_layer < NUM_LAYERS-1: eng_layer increments, go to START. The next eng_start therefore comes 1 cycle after eng_done.
  - On eng_done with eng_layer == NUM_LAYERS-1: result <= eng_class, result_valid <= 1, go to TX.
- TX:
  - Waits while tx_busy = 1.
  - On the first cycle with tx_busy = 0: tx_en = 1 for one cycle, tx_data = 8'h30 + result, then go to IDLE.
  - eng_class values above 9 are sent unchanged as 8'h3A–8'h3F.
- tx_en and eng_start are never asserted in the same cycle.
- Outside TX, tx_en = 0 and tx_data holds its last value.
- new_img while busy sets overrun (sticky) and the image is discarded. overrun clears only on rst or sw_0 low.
- Minimum latency, image to tx_en with the engine taking D cycles per layer and tx idle: 1 + NUM_LAYERS*(D+1) + 1 cycles after the new_img cycle.
- img_out is stable from START until the next accepted image.
- rst or sw_0 low mid-run: return to IDLE immediately, with no tx_en and no eng_start. The engine must tolerate an abandoned run.

Optional Feature:
- Macro: NN_SEQ_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without eng_done: set timeout (sticky, cleared by rst or sw_0 low), keep result_valid = 0, go to TX and send 8'h45 ('E').
  - eng_done in the same cycle as expiry wins: the run completes normally.
- Not defined:
  - No counter is present; timeout is tied to 0.
  - WAIT holds indefinitely until eng_done.

Test Plan:
- input_valid rises with image 121'h1 and the engine returns done after 5 cycles per layer, class 7 -> two eng_start pulses (eng_layer 0 then 1), result=7, result_valid=1, one tx_en with tx_data=8'h37.
- A second, different image while input_valid stays high, after the first completes -> new inference runs; a repeated identical image -> no eng_start.
- Different image during WAIT -> overrun=1, no extra eng_start, first result still sent; sw_0 low clears overrun.
- tx_busy held high 20 cycles at final done -> tx_en exactly once, on the first cycle tx_busy=0; eng_done pulse in START ignored.
- rst asserted during WAIT of layer 1 -> all outputs 0, IDLE, no tx_en; the next image runs from layer 0.
- With NN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, engine never done -> timeout=1 after 50 WAIT cycles, tx_data=8'h45, result_valid=0.

Source files
------------

// File: rtl/nn_inference_seq.sv
// nn_inference_seq: top-level sequencer between the UART image receiver and the
// shared fully-connected layer engine. Detects a newly received image, runs the
// engine once per layer, captures the final class index and sends it back as a
// single ASCII digit through the UART transmitter handshake.
//
// Optional build macro: NN_SEQ_TIMEOUT_EN
//   defined   -> engine watchdog; on expiry the sticky timeout flag is set and
//                'E' (8'h45) is transmitted instead of a digit.
//   undefined -> no watchdog counter, timeout is tied low, WAIT holds until
//                eng_done.
module nn_inference_seq #(
  parameter int NUM_LAYERS     = 2,
  parameter int LAYER_W        = 2,
  parameter int IMG_BITS       = 121,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_0,
  input  logic                input_valid,
  input  logic [IMG_BITS-1:0] network_input,
  output logic [IMG_BITS-1:0] img_out,
  output logic                eng_start,
  output logic [LAYER_W-1:0]  eng_layer,
  input  logic                eng_done,
  input  logic [3:0]          eng_class,
  output logic [7:0]          tx_data,
  output logic                tx_en,
  input  logic                tx_busy,
  output logic [3:0]          result,
  output logic                result_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout
);

  // Reject configurations whose counters cannot hold their terminal values.
  generate
    if ((NUM_LAYERS < 1) ||
        ((NUM_LAYERS - 1) >= (1 << LAYER_W)) ||
        (TIMEOUT_CYCLES < 1) ||
        (64'(TIMEOUT_CYCLES - 1) >= (64'(1) << TO_W))) begin : g_bad_cfg
      $error("nn_inference_seq: LAYER_W or TO_W too narrow for the configuration");
    end
  endgenerate

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_TX    = 2'd3
  } state_t;

  // Class index 0..15 maps onto 8'h30..8'h3F; values above 9 are sent as-is.
  function automatic logic [7:0] f_class_to_ascii(input logic [3:0] i_cls);
    f_class_to_ascii = 8'h30 + {4'h0, i_cls};
  endfunction

  state_t                r_state;
  logic                  r_ivq;
  logic [IMG_BITS-1:0]   r_nq;
  logic [IMG_BITS-1:0]   r_img_out;
  logic                  r_eng_start;
  logic [LAYER_W-1:0]    r_eng_layer;
  logic [7:0]            r_tx_data;
  logic                  r_tx_en;
  logic [3:0]            r_result;
  logic                  r_result_valid;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_tx_err;
  logic                  w_new_img;

`ifdef NN_SEQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // A rising input_valid or a changed image word while valid stays high marks a
  // new image; an identical image re-sent back-to-back is not detected.
  assign w_new_img = (input_valid & ~r_ivq) |
                     (input_valid & r_ivq & (network_input != r_nq));

  assign img_out      = r_img_out;
  assign eng_start    = r_eng_start;
  assign eng_layer    = r_eng_layer;
  assign tx_data      = r_tx_data;
  assign tx_en        = r_tx_en;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

  // One-cycle history of the receiver outputs; keeps tracking while sw_0 is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ivq <= 1'b0;
      r_nq  <= '0;
    end else begin
      r_ivq <= input_valid;
      r_nq  <= network_input;
    end
  end

  // Inference sequencer FSM with all registered outputs; sw_0 low aborts to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_img_out      <= '0;
      r_eng_start    <= 1'b0;
      r_eng_layer    <= '0;
      r_tx_data      <= 8'h00;
      r_tx_en        <= 1'b0;
      r_result       <= 4'h0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_tx_err       <= 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_timeout      <= 1'b0;
`endif
    end else if (!sw_0) begin
      r_state        <= S_IDLE;
      r_img_out      <= '0;
      r_eng_start    <= 1'b0;
      r_eng_layer    <= '0;
      r_tx_data      <= 8'h00;
      r_tx_en        <= 1'b0;
      r_result       <= 4'h0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_tx_err       <= 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_timeout      <= 1'b0;
`endif
    end else begin
      // Pulses default low; they are raised only on the transition that needs them.
      r_eng_start <= 1'b0;
      r_tx_en     <= 1'b0;

      // An image arriving mid-run is discarded and flagged.
      if (w_new_img && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_new_img) begin
            r_img_out      <= network_input;
            r_eng_layer    <= '0;
            r_result_valid <= 1'b0;
            r_eng_start    <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_START;
          end
        end

        S_START: begin
          // eng_done is deliberately ignored while the start pulse is out.
`ifdef NN_SEQ_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (eng_done) begin
            if (r_eng_layer == LAST_LAYER) begin
              r_result       <= eng_class;
              r_result_valid <= 1'b1;
              r_tx_err       <= 1'b0;
              r_state        <= S_TX;
            end else begin
              r_eng_layer <= r_eng_layer + LAYER_W'(1);
              r_eng_start <= 1'b1;
              r_state     <= S_START;
            end
          end
`ifdef NN_SEQ_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_tx_err  <= 1'b1;
            r_state   <= S_TX;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end

        S_TX: begin
          if (!tx_busy) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= r_tx_err ? 8'h45 : f_class_to_ascii(r_result);
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
